// File: rtl/switch_alloc.sv
// Five-port switch allocator: per-output round-robin over head flits, wormhole lock head->tail, credit-gated.
// Latency: grant/out_valid/xbar_sel are combinational from current state and inputs; state updates on the next edge.
// Backpressure: an output grants only while its credit counter is non-zero; blocked requests simply wait upstream.
module switch_alloc #(
  parameter  int NPORT   = 5,
  parameter  int CREDITS = 4,
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORT-1:0]            sw_req,
  input  logic [NPORT-1:0][NPORT-1:0] req_port,
  input  logic [NPORT-1:0]            is_head,
  input  logic [NPORT-1:0]            is_tail,
  input  logic [NPORT-1:0]            credit_in,
  output logic [NPORT-1:0]            grant,
  output logic [NPORT-1:0]            out_valid,
  output logic [NPORT-1:0][2:0]       xbar_sel,
  output logic                        credit_err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

  localparam logic [2:0] SEL_NONE = 3'd7;

  state_e          fsm_q    [NPORT];
  state_e          fsm_d    [NPORT];
  logic [2:0]      owner_q  [NPORT];
  logic [2:0]      owner_d  [NPORT];
  logic [2:0]      rr_q     [NPORT];
  logic [2:0]      rr_d     [NPORT];
  logic [CW-1:0]   credit_q [NPORT];
  logic [CW-1:0]   credit_d [NPORT];
  logic            credit_err_q;
  logic            credit_err_d;

  // vreq[o][i]: input i holds a well-formed request for output o
  logic [NPORT-1:0] req_ok;
  logic [NPORT-1:0] vreq [NPORT];
  // src[o]: input chosen for output o this cycle, SEL_NONE when nothing wins
  logic [2:0]       src  [NPORT];

  // Round-robin pointer step modulo NPORT
  function automatic logic [2:0] wrap_inc(input logic [2:0] x);
    return (x >= 3'(NPORT - 1)) ? 3'd0 : x + 3'd1;
  endfunction

  // Decode requests; zero-hot or multi-hot destinations are dropped entirely
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      req_ok[i] = (req_port[i] != '0) &&
                  ((req_port[i] & (req_port[i] - NPORT'(1))) == '0);
    end
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        vreq[o][i] = sw_req[i] & req_ok[i] & req_port[i][o];
      end
    end
  end

  // Per-output arbitration: locked outputs serve only their owner, idle ones scan heads from rr pointer
  always_comb begin
    logic [2:0] idx;
    idx = '0;
    for (int o = 0; o < NPORT; o++) begin
      src[o] = SEL_NONE;
      if (credit_q[o] != '0) begin
        if (fsm_q[o] == ST_LOCKED) begin
          if (vreq[o][owner_q[o]]) src[o] = owner_q[o];
        end else begin
          idx = rr_q[o];
          for (int k = 0; k < NPORT; k++) begin
            if (src[o] == SEL_NONE && vreq[o][idx] && is_head[idx]) src[o] = idx;
            idx = wrap_inc(idx);
          end
        end
      end
    end
  end

  // Drive crossbar and grant outputs; everything is quiet while reset is held
  always_comb begin
    grant     = '0;
    out_valid = '0;
    for (int o = 0; o < NPORT; o++) xbar_sel[o] = SEL_NONE;
    if (!rst) begin
      for (int o = 0; o < NPORT; o++) begin
        if (src[o] != SEL_NONE) begin
          out_valid[o]     = 1'b1;
          xbar_sel[o]      = src[o];
          grant[src[o]]    = 1'b1;
        end
      end
    end
  end

  // Next-state: packet lock/unlock, pointer advance past the last winner, credit accounting
  always_comb begin
    logic gnt;
    gnt          = 1'b0;
    credit_err_d = credit_err_q;
    for (int o = 0; o < NPORT; o++) begin
      fsm_d[o]    = fsm_q[o];
      owner_d[o]  = owner_q[o];
      rr_d[o]     = rr_q[o];
      credit_d[o] = credit_q[o];

      gnt = (src[o] != SEL_NONE);
      if (gnt) begin
        if (fsm_q[o] == ST_IDLE) begin
          if (is_tail[src[o]]) begin
            rr_d[o] = wrap_inc(src[o]);
          end else begin
            fsm_d[o]   = ST_LOCKED;
            owner_d[o] = src[o];
          end
        end else if (is_tail[src[o]]) begin
          fsm_d[o] = ST_IDLE;
          rr_d[o]  = wrap_inc(owner_q[o]);
        end
      end

      if (gnt && !credit_in[o]) begin
        credit_d[o] = credit_q[o] - CW'(1);
      end else if (!gnt && credit_in[o]) begin
        if (credit_q[o] == CW'(CREDITS)) credit_err_d = 1'b1;
        else                             credit_d[o] = credit_q[o] + CW'(1);
      end
    end
  end

  // State registers with synchronous reset; reset drops any packet lock
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NPORT; o++) begin
        fsm_q[o]    <= ST_IDLE;
        owner_q[o]  <= 3'd0;
        rr_q[o]     <= 3'd0;
        credit_q[o] <= CW'(CREDITS);
      end
      credit_err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        fsm_q[o]    <= fsm_d[o];
        owner_q[o]  <= owner_d[o];
        rr_q[o]     <= rr_d[o];
        credit_q[o] <= credit_d[o];
      end
      credit_err_q <= credit_err_d;
    end
  end

  assign credit_err = credit_err_q;

endmodule

// File: doc/switch_alloc.md
Name: switch_alloc

Overview:
- Switch allocator that sits directly downstream of the five-port input stage and consumes its per-direction switch requests.
- Each cycle it decides which input drives each of the five crossbar outputs, and grants each input at most one output.
- Whole packets are kept contiguous by locking an output to its owner from head flit to tail flit.
- Flits are never sent into a full downstream buffer, because each output has a credit counter.

Parameters:
- NPORT, 5, number of ports; fixed at 5 (Local, N, E, S, W = index 0..4).
- CREDITS, 4, downstream buffer slots per output; credit counter reset value.
- CW, $clog2(CREDITS+1), credit counter width (derived; not to be overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- sw_req  input  [4:0] x1  per-input flit-ready request.
- req_port  input  [4:0] x5  per-input destination, one-hot over outputs.
- is_head  input  [4:0] x1  per-input: the requesting flit is a head flit.
- is_tail  input  [4:0] x1  per-input: the requesting flit is a tail flit (head+tail = single-flit packet).
- credit_in  input  [4:0] x1  per-output: one downstream slot freed this cycle.
- grant  output  [4:0] x1  per-input: flit dequeued and sent this cycle.
- out_valid  output  [4:0] x1  per-output: a flit crosses the crossbar this cycle.
- xbar_sel  output  [2:0] x5  per-output: source input index; 3'd7 when idle.
- credit_err  output  1  sticky: credit_in arrived while the counter was already full.

Behaviour:
- State per output o:
  - fsm: IDLE or LOCKED
  - owner[2:0]
  - rr_ptr[2:0] (range 0..4)
  - credit[CW-1:0]
- All state is registered. grant, out_valid and xbar_sel are combinational from current state and current inputs (zero-cycle latency).
- Request validity:
  - Input i requests output o iff sw_req[i] && req_port[i] is exactly one-hot && req_port[i][o].
  - Zero or multi-hot req_port is ignored: never granted, no state change.
- IDLE:
  - Only requesters with is_head=1 are eligible.
  - If credit[o] > 0, pick the first eligible input scanning rr_ptr, rr_ptr+1, … mod 5.
  - If credit[o] == 0, no grant.
- LOCKED:
  - Only owner is eligible.
  - Grant if owner requests o and credit[o] > 0.
  - Requests from other inputs are blocked.
- On a grant to input i at output o:
  - grant[i]=1, out_valid[o]=1, xbar_sel[o]=i.
  - Otherwise out_valid[o]=0 and xbar_sel[o]=3'd7.
- State transitions at the clock edge:
  - IDLE, granted head and not tail → LOCKED, owner=i.
  - IDLE, granted head+tail → stay IDLE, rr_ptr=(i+1) mod 5.
  - LOCKED, granted tail → IDLE, rr_ptr=(owner+1) mod 5.
  - LOCKED, granted body → stay LOCKED.
  - No grant → no change.
- Credits:
  - Granting output o decrements credit[o]. credit_in[o] increments it.
  - Both in the same cycle → unchanged.
  - credit_in[o] at credit==CREDITS (with no grant) → counter holds and credit_err is set; it stays set until rst.
  - Underflow is impossible because a grant requires credit > 0.
- Outputs are independent. Each input requests at most one output, so at most one grant per input holds by construction.
- Reset, synchronous:
  - All fsm=IDLE, owner=0, rr_ptr=0, credit=CREDITS, credit_err=0.
  - While rst=1, grant and out_valid are forced to 0 and xbar_sel to 3'd7.
  - Reset mid-packet drops the lock immediately; the input side is reset in the same cycle.

Test Plan:
- After rst, inputs 1 and 3 both request output 2 with single-flit packets every cycle → grants alternate 1,3,1,3; xbar_sel[2] is 1,3,1,3; credit[2] reaches 0 after 4 grants, then out_valid[2]=0.
- Input 0 sends a 3-flit packet (head, body, tail) to output 4 while input 2 requests output 4 with a head flit → input 0 granted 3 consecutive cycles, then input 2 granted; xbar_sel[4] is 0,0,0,2.
- CREDITS=4, 4 grants on output 1, then credit_in[1]=1 and a new request in the same cycle → no grant that cycle; grant in the next cycle; credit returns to 0.
- Grant and credit_in on output 3 in the same cycle → credit unchanged.
- credit_in[3] with credit=4 → credit_err=1 and stays 1.
- req_port[2]=5'b00110 with sw_req[2]=1 → no grant on any output, no state change.
- rst asserted while output 4 is LOCKED to input 0 mid-packet → next cycle fsm IDLE, credit=CREDITS, xbar_sel=7; a new head from input 2 is granted immediately after rst deasserts.
